// File: rtl/dump_pkg.sv
// Shared types and Intel-HEX constants for the memory dump engine.
package dump_pkg;

  localparam int unsigned HEX_ADDR_W    = 16;
  localparam logic [7:0]  HEX_DATA_LEN  = 8'h04;
  localparam logic [7:0]  HEX_TYPE_DATA = 8'h00;
  localparam logic [7:0]  HEX_EOF_CKSUM = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    EMIT  = 3'd3,
    ADV   = 3'd4,
    EOF   = 3'd5,
    DONE  = 3'd6
  } dump_state_t;

  typedef struct packed {
    logic [HEX_ADDR_W-1:0] addr;
    logic [31:0]           data;
    logic [7:0]            cksum;
    logic                  eof;
  } hex_rec_t;

endpackage

// File: rtl/hex_cksum.sv
// Intel-HEX data-record checksum: two's complement of the 8-byte record sum.
import dump_pkg::*;

module hex_cksum (
  input  logic [HEX_ADDR_W-1:0] i_addr,
  input  logic [31:0]           i_data,
  output logic [7:0]            o_cksum_c
);

  logic [7:0] w_sum;

  always_comb begin
    w_sum = HEX_DATA_LEN + i_addr[15:8] + i_addr[7:0] + HEX_TYPE_DATA
          + i_data[31:24] + i_data[23:16] + i_data[15:8] + i_data[7:0];
    o_cksum_c = 8'h00 - w_sum;
  end

endmodule

// File: rtl/mem_dump_engine.sv
// Walks system RAM after halt and streams Intel-HEX records for it.
// MEM_DUMP_ZERO_EN: when defined, zero words are emitted too instead of skipped.
import dump_pkg::*;

module mem_dump_engine #(
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned RD_LAT = 4,
  parameter int unsigned IDX_W  = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  output logic             tbCTRL,
  output logic [31:0]      addr,
  output logic             REN,
  input  logic [31:0]      load,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [IDX_W-1:0] rec_addr,
  output logic [31:0]      rec_data,
  output logic [7:0]       rec_cksum,
  output logic             rec_eof,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

  localparam logic [2:0] ST_IDLE  = 3'(IDLE);
  localparam logic [2:0] ST_ISSUE = 3'(ISSUE);
  localparam logic [2:0] ST_WAIT  = 3'(WAIT);
  localparam logic [2:0] ST_EMIT  = 3'(EMIT);
  localparam logic [2:0] ST_ADV   = 3'(ADV);
  localparam logic [2:0] ST_EOF   = 3'(EOF);
  localparam logic [2:0] ST_DONE  = 3'(DONE);

`ifdef MEM_DUMP_ZERO_EN
  localparam logic EMIT_ZERO = 1'b1;
`else
  localparam logic EMIT_ZERO = 1'b0;
`endif

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_word;
  logic             r_tbctrl;
  logic [31:0]      r_addr;
  logic             r_ren;
  logic             r_rec_valid;
  hex_rec_t         r_rec;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_word_nxt;
  logic             w_tbctrl_nxt;
  logic [31:0]      w_addr_nxt;
  logic             w_ren_nxt;
  logic             w_rec_valid_nxt;
  hex_rec_t         w_rec_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [7:0]       w_cksum;

  // Checksum is computed on the next-cycle record so it registers with the fields.
  hex_cksum u_cksum (
    .i_addr    (HEX_ADDR_W'(w_idx_nxt)),
    .i_data    (w_word_nxt),
    .o_cksum_c (w_cksum)
  );

  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_word      <= '0;
      r_tbctrl    <= 1'b0;
      r_addr      <= '0;
      r_ren       <= 1'b0;
      r_rec_valid <= 1'b0;
      r_rec       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_word      <= w_word_nxt;
      r_tbctrl    <= w_tbctrl_nxt;
      r_addr      <= w_addr_nxt;
      r_ren       <= w_ren_nxt;
      r_rec_valid <= w_rec_valid_nxt;
      r_rec       <= w_rec_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_ISSUE;
          w_idx_nxt   = '0;
        end
      end
      ST_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Last WAIT cycle lands the sample exactly RD_LAT cycles after ISSUE.
        if (r_cnt == CNT_W'(RD_LAT - 2)) begin
          w_word_nxt  = load;
          w_state_nxt = ((load != 32'h0) || EMIT_ZERO) ? ST_EMIT : ST_ADV;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_EMIT: begin
        if (rec_ready) w_state_nxt = ST_ADV;
      end
      ST_ADV: begin
        if (r_idx == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = ST_EOF;
        end else begin
          w_idx_nxt   = r_idx + IDX_W'(1);
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_EOF: begin
        if (rec_ready) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase

    // Output decode from the next state so every port comes straight from a flop.
    w_busy_nxt      = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
    w_done_nxt      = (w_state_nxt == ST_DONE);
    w_tbctrl_nxt    = w_busy_nxt;
    w_ren_nxt       = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT);
    w_addr_nxt      = w_tbctrl_nxt ? (32'(w_idx_nxt) << 2) : 32'h0;
    w_rec_valid_nxt = (w_state_nxt == ST_EMIT) || (w_state_nxt == ST_EOF);
    w_rec_nxt       = '0;
    if (w_state_nxt == ST_EMIT) begin
      w_rec_nxt.addr  = HEX_ADDR_W'(w_idx_nxt);
      w_rec_nxt.data  = w_word_nxt;
      w_rec_nxt.cksum = w_cksum;
    end else if (w_state_nxt == ST_EOF) begin
      w_rec_nxt.cksum = HEX_EOF_CKSUM;
      w_rec_nxt.eof   = 1'b1;
    end
  end

  assign tbCTRL    = r_tbctrl;
  assign addr      = r_addr;
  assign REN       = r_ren;
  assign rec_valid = r_rec_valid;
  assign rec_addr  = IDX_W'(r_rec.addr);
  assign rec_data  = r_rec.data;
  assign rec_cksum = r_rec.cksum;
  assign rec_eof   = r_rec.eof;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mem_dump_engine.sv
// Scoreboard bench for mem_dump_engine with a fixed-latency RAM model (DEPTH=4).
`timescale 1ns/1ps
module tb_mem_dump_engine;
  import dump_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned RD_LAT = 4;
  localparam int unsigned IDX_W  = 16;
`ifdef MEM_DUMP_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             nRST = 1'b1;
  logic             start = 1'b0;
  logic             rec_ready = 1'b1;
  logic [31:0]      load = 32'h0;
  logic             tbCTRL, REN, rec_valid, rec_eof, busy, done;
  logic [31:0]      addr, rec_data;
  logic [IDX_W-1:0] rec_addr;
  logic [7:0]       rec_cksum;

  logic [31:0] mem [DEPTH];
  hex_rec_t    sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 CLK = ~CLK;

  mem_dump_engine #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .nRST(nRST), .start(start),
    .tbCTRL(tbCTRL), .addr(addr), .REN(REN), .load(load),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_addr(rec_addr),
    .rec_data(rec_data), .rec_cksum(rec_cksum), .rec_eof(rec_eof),
    .busy(busy), .done(done)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_cksum(input logic [15:0] a, input logic [31:0] d);
    logic [7:0] s;
    s = 8'h04 + a[15:8] + a[7:0] + d[31:24] + d[23:16] + d[15:8] + d[7:0];
    return 8'h00 - s;
  endfunction

  // RAM: data is valid only on the RD_LAT-th cycle of a REN burst, garbage otherwise.
  initial begin : ram_model
    int ren_cnt;
    ren_cnt = 0;
    forever begin
      @(negedge CLK);
      ren_cnt = (REN === 1'b1) ? ren_cnt + 1 : 0;
      load = (ren_cnt == int'(RD_LAT)) ? mem[addr[3:2]] : (32'hBAD0_0000 | 32'(ren_cnt));
    end
  end

  // Every valid cycle must show the scoreboard head; pop on transfer.
  initial begin : monitor
    hex_rec_t e;
    forever begin
      @(negedge CLK);
      if (rec_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_rec", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q[0];
          check_eq("rec_addr",  64'(rec_addr),  64'(e.addr));
          check_eq("rec_data",  64'(rec_data),  64'(e.data));
          check_eq("rec_cksum", 64'(rec_cksum), 64'(e.cksum));
          check_eq("rec_eof",   64'(rec_eof),   64'(e.eof));
          if (rec_ready === 1'b1) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic push_expected(output int exp_cyc, output int n_pushed);
    hex_rec_t r;
    exp_cyc  = 1;
    n_pushed = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      exp_cyc += int'(RD_LAT) + 1;
      if (mem[i] != 32'h0 || ZERO_EN) begin
        r.addr  = 16'(i);
        r.data  = mem[i];
        r.cksum = ref_cksum(16'(i), mem[i]);
        r.eof   = 1'b0;
        sb_q.push_back(r);
        n_pushed++;
        exp_cyc += 1;
      end
    end
    r = '0;
    r.cksum = 8'hFF;
    r.eof   = 1'b1;
    sb_q.push_back(r);
    n_pushed++;
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 nRST = 1'b1;
    @(posedge CLK); #1 nRST = 1'b0;
  endtask

  task automatic run_dump(input bit stall, input string tag);
    int exp_cyc, n_pushed, n, stall_cnt;
    bit stall_req, stalling;
    n = 0; stall_cnt = 0; stall_req = stall; stalling = 1'b0;
    push_expected(exp_cyc, n_pushed);
    if (stall) exp_cyc += 5;
    pulse_start();
    while (done !== 1'b1 && n < 500) begin
      @(posedge CLK); #1 n++;
      if (stalling) begin
        if (stall_cnt == 0) begin rec_ready = 1'b1; stalling = 1'b0; end
        else stall_cnt--;
      end else if (stall_req && rec_valid === 1'b1 && rec_eof === 1'b0 && rec_addr == IDX_W'(1)) begin
        rec_ready = 1'b0; stalling = 1'b1; stall_cnt = 4; stall_req = 1'b0;
      end
    end
    rec_ready = 1'b1;
    check_eq({tag, "_cycles"},   64'(n), 64'(exp_cyc));
    check_eq({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    check_eq({tag, "_done"},     64'(done), 64'd1);
    check_eq({tag, "_tbctrl"},   64'(tbCTRL), 64'd0);
    check_eq({tag, "_busy"},     64'(busy), 64'd0);
  endtask

  initial begin : stim
    int exp_cyc, n_pushed, n;
    // Reset held with start low: everything idle.
    nRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      check_eq("rst_outs", {tbCTRL, REN, rec_valid, rec_eof, busy, done, addr, rec_cksum},
               {6'b0, 32'h0, 8'h0});
    end
    nRST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      check_eq("idle_tbctrl", 64'(tbCTRL), 64'd0);
      check_eq("idle_busy",   64'(busy),   64'd0);
    end
    // Start together with reset: reset wins.
    nRST = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    nRST = 1'b0; start = 1'b0;
    @(posedge CLK); #1;
    check_eq("rst_wins_busy", 64'(busy), 64'd0);

    mem[0] = 32'h0000_0013; mem[1] = 32'hDEAD_BEEF; mem[2] = 32'h0; mem[3] = 32'h0;
    run_dump(1'b0, "basic");

    // DONE ignores start.
    pulse_start();
    repeat (3) @(posedge CLK);
    #1;
    check_eq("done_hold",   64'(done),   64'd1);
    check_eq("done_tbctrl", 64'(tbCTRL), 64'd0);

    do_reset();
    check_eq("rst_done_clr", 64'(done), 64'd0);
    run_dump(1'b1, "stall");

    // Abort in WAIT at i=2.
    do_reset();
    push_expected(exp_cyc, n_pushed);
    pulse_start();
    n = 0;
    while (!(REN === 1'b1 && addr == 32'h8) && n < 200) begin
      @(posedge CLK); #1 n++;
    end
    check_eq("reach_i2", 64'(n < 200), 64'd1);
    @(posedge CLK); #1;
    check_eq("in_wait_ren", 64'(REN), 64'd1);
    nRST = 1'b1;
    @(posedge CLK); #1;
    check_eq("abort_tbctrl", 64'(tbCTRL),    64'd0);
    check_eq("abort_valid",  64'(rec_valid), 64'd0);
    check_eq("abort_ren",    64'(REN),       64'd0);
    check_eq("abort_left",   64'(sb_q.size()), 64'(n_pushed - 2));
    sb_q.delete();
    nRST = 1'b0;
    run_dump(1'b0, "restart");

    // Only the last word non-zero: boundary index DEPTH-1.
    do_reset();
    mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'h0; mem[3] = 32'h1234_5678;
    run_dump(1'b0, "last");

    // All-zero memory.
    do_reset();
    mem[3] = 32'h0;
    run_dump(1'b0, "zero");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_dump_engine.md
Name: mem_dump_engine

Overview:
- Hardware replacement for the bench-side memory dump: sits downstream of the scheduler core `system` and consumes its post-halt state.
- Once `dcif.flushed` is seen (fed in as `start`), it takes the system RAM port (`tbCTRL`/`addr`/`REN`/`load`) and walks memory word by word.
- For every non-zero word it emits one Intel-HEX data record (fields plus checksum) on a valid/ready stream, then one EOF record.
- A file writer or UART bridge consumes the stream.

Parameters:
- DEPTH, 16384, number of 32-bit words walked (word index i = 0..DEPTH-1).
- RD_LAT, 4, cycles from `REN` assertion to `load` being valid (fixed, no handshake).
- IDX_W, 16, width of the record address field; must satisfy DEPTH <= 2^IDX_W.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; synchronous, active-high (asserted = 1). Already decided.
- start  in  1  level or pulse; sampled only in IDLE; normally driven by `dcif.flushed`.
- tbCTRL  out  1  1 = engine owns the RAM port.
- addr  out  32  byte address, i<<2.
- REN  out  1  RAM read enable.
- load  in  32  RAM read data.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts the record.
- rec_addr  out  IDX_W  record address field (= i).
- rec_data  out  32  record data word.
- rec_cksum  out  8  Intel-HEX checksum.
- rec_eof  out  1  1 = EOF record (`:00000001FF`); data fields are 0, checksum = 8'hFF.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (nRST=1 at a CLK edge): state=IDLE; i=0; all outputs 0. Reset mid-dump aborts immediately and releases `tbCTRL` on the next cycle.
- IDLE: all outputs 0. start=1 -> ISSUE, i=0.
- ISSUE: tbCTRL=1, REN=1, addr=i<<2; clear the wait counter; go to WAIT.
- WAIT: hold tbCTRL, REN and addr. Count RD_LAT-1 further cycles, then sample `load` into a register. The sample is taken exactly RD_LAT cycles after ISSUE was entered.
  - Sampled word == 0 -> ADV.
  - Otherwise -> EMIT.
- EMIT: rec_valid=1; rec_addr=i[IDX_W-1:0]; rec_data=sampled word; rec_cksum = 8'h00 - (8'h04 + addr_hi + addr_lo + 8'h00 + the four data bytes), mod 256.
  - All record fields stay stable while rec_valid=1 and rec_ready=0.
  - A transfer occurs on a cycle where valid & ready -> ADV.
  - REN=0 in EMIT; tbCTRL stays 1.
- ADV: if i == DEPTH-1 -> EOF, else i=i+1 -> ISSUE. i never wraps.
- EOF: rec_valid=1, rec_eof=1, rec_cksum=8'hFF. On transfer -> DONE.
- DONE: tbCTRL=0, done=1. Stay until reset; `start` is ignored.
- Cost per word: 1 (ISSUE) + RD_LAT-1 (WAIT) + 1 (ADV), plus EMIT cycles (minimum 1) for non-zero words.
- rec_ready held high permanently: no stalls beyond the FSM costs above.
- start=1 arriving together with reset: reset wins.

Optional Feature:
- MEM_DUMP_ZERO_EN defined: zero words also go through EMIT, so exactly DEPTH data records are emitted, plus EOF.
- Undefined (default): zero words are skipped, matching the existing dump format.

Decomposition:
- Shared package `dump_pkg`:
  - `dump_state_t` enum (IDLE, ISSUE, WAIT, EMIT, ADV, EOF, DONE).
  - HEX_DATA_LEN = 8'h04, HEX_TYPE_DATA = 8'h00, HEX_EOF_CKSUM = 8'hFF.
  - `hex_rec_t` struct {addr, data, cksum, eof}.
- One sub-module, `hex_cksum`: combinational 8-byte sum and two's-complement checksum, unit-testable in isolation.

Test Plan:
- Reset 3 cycles, start never asserted -> all outputs 0, tbCTRL=0 throughout.
- DEPTH=4, memory {0x00000013, 0xDEADBEEF, 0, 0}, rec_ready=1, start pulse:
  - records (addr 0, data 0x00000013, cksum 0xE9), then (addr 1, data 0xDEADBEEF, cksum 0xC3), then EOF (cksum 0xFF);
  - then done=1 and tbCTRL=0.
- Same memory, rec_ready low for 5 cycles during record 1 -> fields stable across the stall; exactly one transfer; no duplicate.
- RD_LAT=4: the WAIT sample at i=1 is taken exactly 4 cycles after ISSUE; changing `load` one cycle earlier or later must not affect rec_data.
- Reset asserted while in WAIT at i=2:
  - next cycle, tbCTRL=0 and rec_valid=0;
  - a restart re-dumps from addr 0.
- MEM_DUMP_ZERO_EN defined, all-zero memory, DEPTH=4 -> 4 records with data 0 and cksums 0xFC, 0xFB, 0xFA, 0xF9, then EOF.
